// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX_FSM between NUM_REQ word sources, with CTS gating and start timeout.
// Optional macro UART_ARB_HIPRI_EN: requester 0 gets strict priority over the round robin.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned START_TIMEOUT = 16
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic [NUM_REQ-1:0]             Req,
   input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
   output logic [NUM_REQ-1:0]             Grant,
   output logic                           Start_Err,
   input  logic                           CTS,
   input  logic                           Tx_Busy,
   output logic [DATA_BITS-1:0]           Tx_Data_In,
   output logic                           Transmit_Start_In,
   output logic [$clog2(NUM_REQ)-1:0]     Active_Id,
   output logic                           Arb_Busy
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = $clog2(START_TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_e;

   state_e               state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 start_q, start_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;

   logic                 win_found;
   logic [IDW-1:0]       win_idx;
   logic [IDW-1:0]       cand;
   logic [IDW-1:0]       adv_ptr;

   // First requester at or after ptr, wrapping
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDW'((32'(ptr_q) + i) % NUM_REQ);
         if (!win_found && Req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`ifdef UART_ARB_HIPRI_EN
      if (Req[0]) begin
         win_found = 1'b1;
         win_idx   = '0;
      end
`endif
   end

   // Pointer value after the current owner finishes (granted or timed out)
   always_comb begin
      adv_ptr = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
`ifdef UART_ARB_HIPRI_EN
      if (id_q == '0) adv_ptr = ptr_q;
`endif
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      start_d = start_q;
      err_d   = 1'b0;
      grant_d = '0;
      case (state_q)
         IDLE: begin
            if (CTS && !Tx_Busy && win_found) begin
               state_d = START;
               id_d    = win_idx;
               data_d  = Req_Data[32'(win_idx)*DATA_BITS +: DATA_BITS];
               start_d = 1'b1;
               cnt_d   = '0;
            end
         end
         START: begin
            if (Tx_Busy) begin
               start_d       = 1'b0;
               grant_d[id_q] = 1'b1;
               ptr_d         = adv_ptr;
               state_d       = WAIT_DONE;
            end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
               start_d = 1'b0;
               err_d   = 1'b1;
               ptr_d   = adv_ptr;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_DONE: begin
            if (!Tx_Busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         start_q <= start_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         grant_q <= grant_d;
      end
   end

   assign Grant             = grant_q;
   assign Start_Err         = err_q;
   assign Tx_Data_In        = data_q;
   assign Transmit_Start_In = start_q;
   assign Active_Id         = id_q;
   assign Arb_Busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a transaction-level round-robin model predicts
// each word's owner, data and outcome; a negedge monitor checks them as the DUT presents them.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DW      = 8;
   localparam int TO      = 16;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [3:0]  Req;
   logic [31:0] Req_Data;
   logic [3:0]  Grant;
   logic        Start_Err;
   logic        CTS;
   logic        Tx_Busy;
   logic [7:0]  Tx_Data_In;
   logic        Transmit_Start_In;
   logic [1:0]  Active_Id;
   logic        Arb_Busy;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_BITS(DW), .START_TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data), .Grant(Grant),
      .Start_Err(Start_Err), .CTS(CTS), .Tx_Busy(Tx_Busy), .Tx_Data_In(Tx_Data_In),
      .Transmit_Start_In(Transmit_Start_In), .Active_Id(Active_Id), .Arb_Busy(Arb_Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         id;
      logic [7:0] data;
      bit         acked;
   } exp_t;

   exp_t exp_q[$];
   int   tx_q[$];
   int   forced_q[$];
   int   m_ptr;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cts_low  = 0;
   bit   rnd_cts  = 0;
   bit   mon_en   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference arbitration: strict priority (if enabled), else first pending from ptr with wrap
   function automatic int pick(input logic [3:0] pend, input int ptr);
`ifdef UART_ARB_HIPRI_EN
      if (pend[0]) return 0;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pend[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // Plan a whole batch: each arbitration's winner, data and outcome (-1 = transmitter never acks)
   task automatic plan(input logic [3:0] mask, input logic [31:0] data);
      logic [3:0] pend;
      int w, o;
      pend = mask;
      while (pend != 4'b0) begin
         w = pick(pend, m_ptr);
         if (forced_q.size() > 0) o = forced_q.pop_front();
         else o = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
         tx_q.push_back(o);
         exp_q.push_back('{w, data[w*8 +: 8], o >= 0});
`ifdef UART_ARB_HIPRI_EN
         if (w != 0) m_ptr = (w + 1) % NUM_REQ;
`else
         m_ptr = (w + 1) % NUM_REQ;
`endif
         if (o >= 0) pend[w] = 1'b0;
      end
   endtask

   task automatic apply_cts();
      if (cts_low > 0) begin
         CTS = 1'b0;
         cts_low--;
      end else begin
         CTS = 1'b1;
         if (rnd_cts && $urandom_range(0, 15) == 0) cts_low = int'($urandom_range(1, 4));
      end
   endtask

   // One cycle: requesters drop on Grant, idle slots scramble their data
   task automatic tick();
      @(posedge Clk);
      #1;
      Req = Req & ~Grant;
      for (int i = 0; i < NUM_REQ; i++) if (!Req[i]) Req_Data[i*8 +: 8] = 8'($urandom);
      apply_cts();
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
         tick();
         if (Req == 4'b0 && !Arb_Busy && exp_q.size() == 0) done = 1;
      end
      chk("batch_done", 32'(done), 32'd1);
      chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
   endtask

   task automatic run_batch(input logic [3:0] mask, input logic [31:0] data, input int cts0);
      plan(mask, data);
      Req_Data = data;
      cts_low  = cts0;
      apply_cts();
      Req = mask;
      wait_idle();
   endtask

   // TX_FSM model: raise Tx_Busy some cycles after a start, or never for a planned timeout
   int tx_wait, tx_hold;
   bit tx_active;
   initial begin
      Tx_Busy   = 1'b0;
      tx_active = 0;
      forever begin
         @(posedge Clk);
         #1;
         if (!Rst) begin
            Tx_Busy   = 1'b0;
            tx_active = 0;
         end else begin
            if (!tx_active && Transmit_Start_In) begin
               tx_active = 1;
               tx_wait   = (tx_q.size() > 0) ? tx_q.pop_front() : -1;
               tx_hold   = int'($urandom_range(1, 5));
            end
            if (tx_active) begin
               if (tx_wait > 0) tx_wait--;
               else if (tx_wait == 0) begin
                  if (tx_hold > 0) begin
                     Tx_Busy = 1'b1;
                     tx_hold--;
                  end else begin
                     Tx_Busy   = 1'b0;
                     tx_active = 0;
                  end
               end else if (!Transmit_Start_In) tx_active = 0;
            end
         end
      end
   end

   // Monitor: pop the expected word on each start and check its outcome
   exp_t       cur;
   bit         cur_valid = 0;
   bit         start_prev = 0, prev_cts = 0, prev_busy = 0;
   int         hi_cnt = 0;
   logic [3:0] eg;
   always @(negedge Clk) begin
      if (!Rst || !mon_en) begin
         start_prev = 0;
         cur_valid  = 0;
      end else begin
         if (Transmit_Start_In && !start_prev) begin
            chk("start_needs_cts", 32'(prev_cts), 32'd1);
            chk("start_needs_tx_idle", 32'(prev_busy), 32'd0);
            hi_cnt = 1;
            if (exp_q.size() == 0) begin
               chk("unexpected_start", 32'(exp_q.size()), 32'd1);
               cur_valid = 0;
            end else begin
               cur       = exp_q.pop_front();
               cur_valid = 1;
               chk("active_id", 32'(Active_Id), 32'(cur.id));
               chk("tx_data_at_start", 32'(Tx_Data_In), 32'(cur.data));
               chk("arb_busy_at_start", 32'(Arb_Busy), 32'd1);
            end
         end else if (Transmit_Start_In) hi_cnt++;
         if (Grant != 4'b0 || Start_Err) begin
            if (!cur_valid) chk("orphan_grant_or_err", 32'({Start_Err, Grant}), 32'd0);
            else begin
               eg = cur.acked ? 4'(1 << cur.id) : 4'b0;
               chk("grant_vector", 32'(Grant), 32'(eg));
               chk("start_err", 32'(Start_Err), 32'(!cur.acked));
               chk("tx_data_at_end", 32'(Tx_Data_In), 32'(cur.data));
               if (cur.acked) chk("busy_before_grant", 32'(prev_busy), 32'd1);
               else chk("start_high_cycles", 32'(hi_cnt), 32'(TO));
               cur_valid = 0;
            end
         end
         start_prev = Transmit_Start_In;
      end
      prev_cts  = CTS;
      prev_busy = Tx_Busy;
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_arb_busy"}, 32'(Arb_Busy), 32'd0);
      chk({tag, "_start"}, 32'(Transmit_Start_In), 32'd0);
      chk({tag, "_grant"}, 32'(Grant), 32'd0);
      chk({tag, "_err"}, 32'(Start_Err), 32'd0);
      chk({tag, "_active_id"}, 32'(Active_Id), 32'd0);
      chk({tag, "_tx_data"}, 32'(Tx_Data_In), 32'd0);
   endtask

   initial begin
      bit started, saw_grant;
      logic [31:0] d;
      Rst = 1'b0; Req = 4'b0; Req_Data = 32'b0; CTS = 1'b1; m_ptr = 0;
      repeat (3) @(posedge Clk);
      #1;
      chk_all_zero("reset");
      Rst    = 1'b1;
      mon_en = 1;

      // Idle with no requests
      repeat (20) tick();
      chk_all_zero("idle20");

      // All four requesting, every start acknowledged
      forced_q = '{2, 0, 3, 1};
      run_batch(4'hF, 32'h44_33_22_11, 0);

      // CTS low for 8 cycles holds off requester 2
      run_batch(4'b0100, 32'h00_A5_00_00, 8);

      // Timeout on requester 1, then requester 2 is favoured
      forced_q = '{-1, 1, 2};
      run_batch(4'b0110, 32'h00_C3_5A_00, 0);

      run_batch(4'b1011, $urandom, 0);

      // Reset while requester 3's start is outstanding
      mon_en = 0;
      tx_q.push_back(-1);
      Req_Data = 32'h7E_00_00_00;
      Req = 4'b1000;
      started = 0; saw_grant = 0;
      for (int c = 0; c < 40 && !started; c++) begin
         tick();
         if (Transmit_Start_In) started = 1;
         if (Grant != 4'b0) saw_grant = 1;
      end
      chk("rst_test_started", 32'(started), 32'd1);
      repeat (2) begin
         tick();
         if (Grant != 4'b0) saw_grant = 1;
      end
      #2 Rst = 1'b0;
      #1;
      chk_all_zero("async_rst");
      chk("rst_no_grant", 32'(saw_grant), 32'd0);
      tx_q.delete(); exp_q.delete(); forced_q.delete();
      m_ptr = 0;
      plan(4'b1000, Req_Data);
      mon_en = 1;
      @(posedge Clk);
      #3 Rst = 1'b1;
      wait_idle();

      // Randomized batches with random CTS drops
      rnd_cts = 1;
      for (int b = 0; b < 40; b++) begin
         d = $urandom;
         run_batch(4'($urandom_range(1, 15)), d,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0);
      end
      rnd_cts = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
